pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central hazard scheduler for the 5-stage MIPS pipeline (IF, ID, EX, MEM, WB). It keeps a shadow copy of the destination and control bits of every in-flight instruction. From that copy it drives the PC enable, the pipe-register enables, bubbles and flushes, and the EX-stage forwarding selects. It replaces separate stall and forwarding decisions with one sequenced controller. Branches are predicted not-taken and redirect from MEM, matching where PCSrc and jump resolve.

Parameters:
REG_AW, 5, register-address width
CNT_W, 16, width of saturating performance counters

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous reset, active-high
id_valid  in  1  ID holds a real instruction
id_rs  in  REG_AW  ID source A (instr[25:21])
id_rt  in  REG_AW  ID source B (instr[20:16])
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt as a register (not an immediate)
id_wreg  in  REG_AW  ID destination after the RegDst mux
id_regwrite  in  1  ID instruction writes the register file
id_memread  in  1  ID instruction is a load
mem_redirect  in  1  taken branch or jump currently in MEM
pc_en  out  1  PC may advance
if_id_en  out  1  IF/ID register captures
if_id_flush  out  1  IF/ID register loads a NOP
id_ex_bubble  out  1  ID/EX register loads a NOP
ex_mem_bubble  out  1  EX/MEM register loads a NOP
fwd_a  out  2  EX operand A: 00 regfile, 01 MEM ALU result, 10 WB data
fwd_b  out  2  EX operand B, same encoding
id_byp_a  out  1  ID read A must take WB write data
id_byp_b  out  1  ID read B must take WB write data
stall_cnt  out  CNT_W  load-use stall cycles
flush_cnt  out  CNT_W  redirect events
hazard_err  out  1  sticky: illegal forward from a load in MEM

Behaviour:
- Shadow stages ex/mem/wb each hold: valid, rs, rt, use_rs, use_rt, wreg, regwrite, memread. ex also records rs/rt at capture.
- Every posedge the shadow advances: wb<=mem; mem<=ex_mem_bubble ? NOP : ex; ex<=id_ex_bubble ? NOP : ID inputs (qualified by id_valid).
- A NOP has valid=0 and regwrite=0.
- A producer P matches source s when P.valid & P.regwrite & P.wreg==s & s!=0.
- load_use (combinational) = id_valid & ex.memread & ex matches a used ID source.
- Priority, highest first: RST, mem_redirect, load_use, normal.
- RST cycle: shadow cleared to NOP; counters 0; hazard_err 0; pc_en=0, if_id_en=0; all flush/bubble outputs 1; fwd=00.
- mem_redirect: pc_en=1 (the pipeline loads the target); if_id_flush=1, id_ex_bubble=1, ex_mem_bubble=1. This kills the 3 younger instructions. load_use is ignored in the same cycle. flush_cnt+1.
- load_use without redirect: pc_en=0, if_id_en=0, id_ex_bubble=1, stall_cnt+1. Exactly 1 stall cycle follows. Next cycle the load is in MEM, and the consumer receives the data via WB forward.
- Normal: pc_en=1, if_id_en=1, all flush/bubble outputs 0.
- Forwarding from the ex shadow source: 01 if mem matches and !mem.memread; else 10 if wb matches; else 00. The youngest producer wins.
- If mem matches and mem.memread is set, the select is 00 and hazard_err is set.
- ID bypass: id_byp_a=wb matches id_rs & id_use_rs; id_byp_b likewise for rt.
- Counters saturate at all-ones, never wrap.
- Register $0 never stalls, forwards or bypasses.
- Reset mid-stall or mid-flush: RST dominates. The cycle after RST releases is normal with an empty shadow.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10
  - stage-record struct {valid, rs, rt, use_rs, use_rt, wreg, regwrite, memread}
  - NOP record constant
- One sub-module, hz_match: combinational producer/source compare. It is instantiated per (stage, source) pair.
- Counters and shadow registers stay in the top module.

Test Plan:
1. lw $2 in EX, ID add $3,$2,$4 -> one cycle of pc_en=0, if_id_en=0, id_ex_bubble=1, stall_cnt=1. Two cycles later fwd_a=10.
2. add $5 in MEM, sub with rs=$5 in EX -> fwd_a=01. With add $5 also in WB, fwd_a stays 01 (youngest wins).
3. mem_redirect=1 while load_use holds -> pc_en=1; if_id_flush, id_ex_bubble, ex_mem_bubble all 1; stall_cnt unchanged; flush_cnt+1.
4. Producer writes $0, consumer reads $0 -> no stall, fwd=00, byp=0.
5. WB writes $7 while ID reads rt=$7 (use_rt=1) -> id_byp_b=1, id_byp_a=0.
6. RST asserted during a stall, then 0x1_0000 forced redirects -> outputs at reset values; afterwards flush_cnt saturates at 0xFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects and the
// per-stage shadow record of an in-flight instruction.
package pipe_ctrl_pkg;

  localparam int unsigned RegAw = 5;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef struct packed {
    logic             valid;
    logic [RegAw-1:0] rs;
    logic [RegAw-1:0] rt;
    logic             use_rs;
    logic             use_rt;
    logic [RegAw-1:0] wreg;
    logic             regwrite;
    logic             memread;
  } stage_t;

  localparam stage_t STAGE_NOP = '0;

endpackage

// File: rtl/hz_match.sv
// Producer/source compare: a live register writer targeting a nonzero source.
module hz_match #(
  parameter int unsigned AW = 5
) (
  input  logic          p_valid_i,
  input  logic          p_regwrite_i,
  input  logic [AW-1:0] p_wreg_i,
  input  logic [AW-1:0] src_i,
  output logic          match_o
);

  assign match_o = p_valid_i & p_regwrite_i & (p_wreg_i == src_i) & (src_i != '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard scheduler for a 5-stage pipeline: shadows EX/MEM/WB, resolves
// load-use stalls, MEM-stage redirects, EX forwarding and ID write-through bypass.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REG_AW = RegAw,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_wreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              mem_redirect,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              ex_mem_bubble,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              id_byp_a,
  output logic              id_byp_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              hazard_err
);

  stage_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_rec;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  logic hazard_err_q, hazard_err_d;

  logic [REG_AW-1:0] id_src [2];
  logic [REG_AW-1:0] ex_src [2];
  logic [1:0] ex_id_m, mem_ex_m, wb_ex_m, wb_id_m;
  logic [1:0] id_use, ex_use, mem_hit, wb_hit;
  logic [1:0] fwd_sel [2];
  logic load_use, illegal;

  assign id_src[0] = id_rs;
  assign id_src[1] = id_rt;
  assign ex_src[0] = ex_q.rs;
  assign ex_src[1] = ex_q.rt;
  assign id_use    = {id_use_rt, id_use_rs};
  assign ex_use    = {ex_q.use_rt, ex_q.use_rs};

  for (genvar g = 0; g < 2; g++) begin : g_src
    hz_match #(.AW(REG_AW)) u_ex_id (
      .p_valid_i(ex_q.valid), .p_regwrite_i(ex_q.regwrite), .p_wreg_i(ex_q.wreg),
      .src_i(id_src[g]), .match_o(ex_id_m[g])
    );
    hz_match #(.AW(REG_AW)) u_mem_ex (
      .p_valid_i(mem_q.valid), .p_regwrite_i(mem_q.regwrite), .p_wreg_i(mem_q.wreg),
      .src_i(ex_src[g]), .match_o(mem_ex_m[g])
    );
    hz_match #(.AW(REG_AW)) u_wb_ex (
      .p_valid_i(wb_q.valid), .p_regwrite_i(wb_q.regwrite), .p_wreg_i(wb_q.wreg),
      .src_i(ex_src[g]), .match_o(wb_ex_m[g])
    );
    hz_match #(.AW(REG_AW)) u_wb_id (
      .p_valid_i(wb_q.valid), .p_regwrite_i(wb_q.regwrite), .p_wreg_i(wb_q.wreg),
      .src_i(id_src[g]), .match_o(wb_id_m[g])
    );
  end

  assign load_use = id_valid & ex_q.memread & |(ex_id_m & id_use);
  // Only operands the EX instruction actually reads may forward or flag an error.
  assign mem_hit  = mem_ex_m & ex_use;
  assign wb_hit   = wb_ex_m & ex_use;
  assign illegal  = |mem_hit & mem_q.memread;

  always_comb begin
    for (int g = 0; g < 2; g++) begin
      if (mem_hit[g]) fwd_sel[g] = mem_q.memread ? FWD_REG : FWD_MEM;
      else if (wb_hit[g]) fwd_sel[g] = FWD_WB;
      else fwd_sel[g] = FWD_REG;
    end
  end

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    fwd_a         = fwd_sel[0];
    fwd_b         = fwd_sel[1];
    id_byp_a      = wb_id_m[0] & id_use_rs;
    id_byp_b      = wb_id_m[1] & id_use_rt;
    if (RST) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      fwd_a         = FWD_REG;
      fwd_b         = FWD_REG;
      id_byp_a      = 1'b0;
      id_byp_b      = 1'b0;
    end else if (mem_redirect) begin
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (load_use) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_bubble  = 1'b1;
    end
  end

  always_comb begin
    id_rec = STAGE_NOP;
    if (id_valid) begin
      id_rec = '{valid: 1'b1, rs: id_rs, rt: id_rt, use_rs: id_use_rs, use_rt: id_use_rt,
                 wreg: id_wreg, regwrite: id_regwrite, memread: id_memread};
    end
    ex_d  = id_ex_bubble ? STAGE_NOP : id_rec;
    mem_d = ex_mem_bubble ? STAGE_NOP : ex_q;
    wb_d  = mem_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (mem_redirect && flush_cnt_q != '1) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
    if (!mem_redirect && load_use && stall_cnt_q != '1) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    hazard_err_d = hazard_err_q | illegal;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_q         <= STAGE_NOP;
      mem_q        <= STAGE_NOP;
      wb_q         <= STAGE_NOP;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      hazard_err_q <= 1'b0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      hazard_err_q <= hazard_err_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign hazard_err = hazard_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a queue-based pipeline model predicts
// every cycle's outputs; a negedge monitor pops and compares.
module tb_pipe_hazard_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned CNT_W  = 16;
  localparam int          CntMax = 65535;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic id_valid = 1'b0, id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic id_regwrite = 1'b0, id_memread = 1'b0, mem_redirect = 1'b0;
  logic [REG_AW-1:0] id_rs = '0, id_rt = '0, id_wreg = '0;
  logic pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_bubble;
  logic [1:0] fwd_a, fwd_b;
  logic id_byp_a, id_byp_b, hazard_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wreg(id_wreg),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .mem_redirect(mem_redirect),
    .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble), .fwd_a(fwd_a),
    .fwd_b(fwd_b), .id_byp_a(id_byp_a), .id_byp_b(id_byp_b), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .hazard_err(hazard_err)
  );

  typedef struct {
    bit valid; int rs; int rt; bit use_rs; bit use_rt; int wreg; bit rw; bit mr;
  } instr_t;

  typedef struct packed {
    logic pc_en; logic if_id_en; logic if_id_flush; logic id_ex_bubble; logic ex_mem_bubble;
    logic [1:0] fwd_a; logic [1:0] fwd_b; logic byp_a; logic byp_b;
    logic [15:0] stall_cnt; logic [15:0] flush_cnt; logic err;
  } obs_t;

  obs_t   exp_q[$];
  instr_t pipe[$];  // [0]=EX, [1]=MEM, [2]=WB
  instr_t nop;
  int m_stall = 0, m_flush = 0;
  bit m_err = 0;
  int vectors = 0, miscompares = 0;
  obs_t got;

  assign got = {pc_en, if_id_en, if_id_flush, id_ex_bubble, ex_mem_bubble, fwd_a, fwd_b,
                id_byp_a, id_byp_b, stall_cnt, flush_cnt, hazard_err};

  function automatic bit writes(input instr_t p, input int s);
    return p.valid && p.rw && p.wreg == s && s != 0;
  endfunction

  // Youngest producer first: MEM then WB; a load in MEM cannot supply its data.
  function automatic logic [1:0] fwd_of(input bit used, input int s, output bit ill);
    ill = 0;
    if (!used) return 2'd0;
    if (writes(pipe[1], s)) begin
      if (pipe[1].mr) begin
        ill = 1;
        return 2'd0;
      end
      return 2'd1;
    end
    if (writes(pipe[2], s)) return 2'd2;
    return 2'd0;
  endfunction

  task automatic step(input bit rst, input bit redir, input bit idv, input int rs,
                      input int rt, input bit urs, input bit urt, input int wr,
                      input bit rw, input bit mr);
    obs_t e;
    instr_t nw;
    bit lu, ill_a, ill_b;
    logic [1:0] fa, fb;
    RST = rst; mem_redirect = redir; id_valid = idv;
    id_rs = REG_AW'(rs); id_rt = REG_AW'(rt); id_use_rs = urs; id_use_rt = urt;
    id_wreg = REG_AW'(wr); id_regwrite = rw; id_memread = mr;

    lu = idv && pipe[0].mr && ((urs && writes(pipe[0], rs)) || (urt && writes(pipe[0], rt)));
    fa = fwd_of(pipe[0].use_rs, pipe[0].rs, ill_a);
    fb = fwd_of(pipe[0].use_rt, pipe[0].rt, ill_b);
    e = '0;
    e.stall_cnt = 16'(m_stall);
    e.flush_cnt = 16'(m_flush);
    e.err = m_err;
    if (rst) begin
      e.if_id_flush = 1; e.id_ex_bubble = 1; e.ex_mem_bubble = 1;
    end else begin
      e.fwd_a = fa; e.fwd_b = fb;
      e.byp_a = urs && writes(pipe[2], rs);
      e.byp_b = urt && writes(pipe[2], rt);
      if (redir) begin
        e.pc_en = 1; e.if_id_en = 1; e.if_id_flush = 1; e.id_ex_bubble = 1;
        e.ex_mem_bubble = 1;
      end else if (lu) begin
        e.id_ex_bubble = 1;
      end else begin
        e.pc_en = 1; e.if_id_en = 1;
      end
    end
    exp_q.push_back(e);

    if (rst) begin
      pipe = '{nop, nop, nop};
      m_stall = 0; m_flush = 0; m_err = 0;
    end else begin
      if (ill_a || ill_b) m_err = 1;
      if (redir) m_flush = (m_flush < CntMax) ? m_flush + 1 : CntMax;
      else if (lu) m_stall = (m_stall < CntMax) ? m_stall + 1 : CntMax;
      nw = nop;
      if (idv && !redir && !lu) nw = '{1, rs, rt, urs, urt, wr, rw, mr};
      void'(pipe.pop_back());
      pipe.push_front(nw);
      if (redir) pipe[1] = nop;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    forever begin
      obs_t e;
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL out_vec #%0d t=%0t got=%h expected=%h", vectors, $time, got, e);
        end
      end
    end
  end

  initial begin
    nop = '{0, 0, 0, 0, 0, 0, 0, 0};
    pipe = '{nop, nop, nop};
    @(posedge CLK);
    #1;
    // reset state
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // lw $2 then add $3,$2,$4: one stall, held ID, later WB forward
    step(0, 0, 1, 1, 2, 1, 0, 2, 1, 1);
    step(0, 0, 1, 2, 4, 1, 1, 3, 1, 0);
    step(0, 0, 1, 2, 4, 1, 1, 3, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // add $5 twice then sub using $5: youngest (MEM) wins
    step(0, 0, 1, 1, 1, 1, 1, 5, 1, 0);
    step(0, 0, 1, 1, 1, 1, 1, 5, 1, 0);
    step(0, 0, 1, 5, 6, 1, 1, 7, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // redirect while a load-use holds
    step(0, 0, 1, 3, 9, 1, 0, 8, 1, 1);
    step(0, 1, 1, 8, 0, 1, 0, 9, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // $0 producer/consumer
    step(0, 0, 1, 1, 1, 1, 0, 0, 1, 1);
    step(0, 0, 1, 0, 0, 1, 1, 4, 1, 0);
    step(0, 0, 1, 0, 0, 1, 1, 4, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // WB writes $7 while ID reads rt=$7
    step(0, 0, 1, 1, 1, 1, 0, 7, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 3, 7, 1, 1, 2, 1, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom), int'($urandom_range(0, 7)),
           1'($urandom), 1'($urandom));
    end
    // reset mid-stall, then flush counter saturation
    step(0, 0, 1, 1, 1, 1, 0, 6, 1, 1);
    step(0, 0, 1, 6, 2, 1, 1, 3, 1, 0);
    step(1, 0, 1, 6, 2, 1, 1, 3, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32'h1_0000; i++) step(0, 1, 1, 1, 2, 1, 1, 3, 1, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    @(negedge CLK);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
